// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - round-robin arbiter sharing the register-file port between host bridge (A) and telemetry (B)
module reg_file_arbiter #(
  parameter logic [5:0] MAX_ADDR = 6'h25
) (
  input  logic       clock,
  input  logic       reset_n,
  // requester A (host bridge)
  input  logic       a_req,
  input  logic       a_we,
  input  logic [5:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  output logic       a_err,
  // requester B (telemetry sequencer)
  input  logic       b_req,
  input  logic       b_we,
  input  logic [5:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic       b_err,
  // register-file access port
  output logic [5:0] address,
  output logic       write_en,
  output logic [7:0] wr_data,
  output logic       read_en,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t     state, state_nx;
  logic       last_grant, last_grant_nx;
  logic [5:0] address_nx;
  logic [7:0] wr_data_nx;
  logic       write_en_nx, read_en_nx, busy_nx;
  logic       a_gnt_nx, b_gnt_nx, a_err_nx, b_err_nx;
  logic       a_rvalid_nx, b_rvalid_nx;
  logic [7:0] a_rdata_nx, b_rdata_nx;

  logic       win_b;
  logic       win_we;
  logic [5:0] win_addr;
  logic [7:0] win_wdata;

  // FSM state and round-robin pointer; last_grant also names the owner of the access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  // next-state, winner selection and next values of every registered output
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    address_nx    = address;
    wr_data_nx    = wr_data;
    write_en_nx   = 1'b0;
    read_en_nx    = 1'b0;
    a_gnt_nx      = 1'b0;
    b_gnt_nx      = 1'b0;
    a_err_nx      = 1'b0;
    b_err_nx      = 1'b0;
    a_rvalid_nx   = 1'b0;
    b_rvalid_nx   = 1'b0;
    a_rdata_nx    = a_rdata;
    b_rdata_nx    = b_rdata;
    // B wins when it is alone, or when both ask and A was served last
    win_b         = b_req && (!a_req || (last_grant == GRANT_A));
    win_we        = win_b ? b_we    : a_we;
    win_addr      = win_b ? b_addr  : a_addr;
    win_wdata     = win_b ? b_wdata : a_wdata;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          address_nx    = win_addr;
          wr_data_nx    = win_wdata;
          last_grant_nx = win_b ? GRANT_B : GRANT_A;
          a_gnt_nx      = !win_b;
          b_gnt_nx      = win_b;
          state_nx      = ISSUE;
          if (win_addr > MAX_ADDR) begin
            // rejected access: granted so the requester can move on, never strobed
            a_err_nx = !win_b;
            b_err_nx = win_b;
          end else begin
            write_en_nx = win_we;
            read_en_nx  = !win_we;
          end
        end
      end
      ISSUE: begin
        // read_en is high here only for an in-range read
        state_nx = read_en ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        if (last_grant == GRANT_B) begin
          b_rdata_nx  = rd_data;
          b_rvalid_nx = 1'b1;
        end else begin
          a_rdata_nx  = rd_data;
          a_rvalid_nx = 1'b1;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address  <= 6'd0;
      wr_data  <= 8'd0;
      write_en <= 1'b0;
      read_en  <= 1'b0;
      busy     <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= 8'd0;
      b_rdata  <= 8'd0;
    end else begin
      address  <= address_nx;
      wr_data  <= wr_data_nx;
      write_en <= write_en_nx;
      read_en  <= read_en_nx;
      busy     <= busy_nx;
      a_gnt    <= a_gnt_nx;
      b_gnt    <= b_gnt_nx;
      a_err    <= a_err_nx;
      b_err    <= b_err_nx;
      a_rvalid <= a_rvalid_nx;
      b_rvalid <= b_rvalid_nx;
      a_rdata  <= a_rdata_nx;
      b_rdata  <= b_rdata_nx;
    end
  end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - self-checking bench for reg_file_arbiter against a transaction-level model
module tb_reg_file_arbiter;

  localparam logic [5:0] MAX_ADDR = 6'h25;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [5:0] a_addr = 6'd0, b_addr = 6'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;
  logic       a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic [5:0] address;
  logic       write_en, read_en, busy;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'd0;

  always #5 clock = ~clock;

  reg_file_arbiter #(.MAX_ADDR(MAX_ADDR)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .address(address), .write_en(write_en), .wr_data(wr_data),
    .read_en(read_en), .rd_data(rd_data), .busy(busy)
  );

  // register file stand-in: registered read, write on strobe
  logic [7:0] init_mem [64];
  logic [7:0] env_mem  [64];
  logic       env_loaded = 1'b0;
  always @(posedge clock) begin
    if (!env_loaded) begin
      env_mem    <= init_mem;
      env_loaded <= 1'b1;
    end else begin
      if (write_en) env_mem[address] <= wr_data;
      if (read_en)  rd_data <= env_mem[address];
    end
  end

  // transaction-level model
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_mem [64];
  logic       m_last_b;
  int         m_busy_left;
  int         m_rv_wait;
  logic       m_rv_b;
  logic [7:0] m_rv_val;
  logic [5:0] e_address;
  logic [7:0] e_wr_data, e_a_rdata, e_b_rdata;
  logic       e_write_en, e_read_en, e_busy;
  logic       e_a_gnt, e_b_gnt, e_a_err, e_b_err, e_a_rvalid, e_b_rvalid;

  task automatic model_reset();
    m_last_b    = 1'b1;
    m_busy_left = 0;
    m_rv_wait   = 0;
    m_rv_b      = 1'b0;
    m_rv_val    = 8'd0;
    e_address   = 6'd0;  e_wr_data = 8'd0;
    e_write_en  = 1'b0;  e_read_en = 1'b0; e_busy = 1'b0;
    e_a_gnt     = 1'b0;  e_b_gnt = 1'b0;  e_a_err = 1'b0; e_b_err = 1'b0;
    e_a_rvalid  = 1'b0;  e_b_rvalid = 1'b0;
    e_a_rdata   = 8'd0;  e_b_rdata = 8'd0;
  endtask

  // expected outputs after the coming clock edge, from the current requests
  task automatic model_edge();
    logic       pick_b, we;
    logic [5:0] ad;
    logic [7:0] wd;
    e_a_gnt = 1'b0; e_b_gnt = 1'b0; e_a_err = 1'b0; e_b_err = 1'b0;
    e_a_rvalid = 1'b0; e_b_rvalid = 1'b0; e_write_en = 1'b0; e_read_en = 1'b0;
    if (m_rv_wait > 0) begin
      m_rv_wait--;
      if (m_rv_wait == 0) begin
        if (m_rv_b) begin e_b_rvalid = 1'b1; e_b_rdata = m_rv_val; end
        else        begin e_a_rvalid = 1'b1; e_a_rdata = m_rv_val; end
      end
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (a_req || b_req) begin
      pick_b = (a_req && b_req) ? !m_last_b : b_req;
      we = pick_b ? b_we : a_we;
      ad = pick_b ? b_addr : a_addr;
      wd = pick_b ? b_wdata : a_wdata;
      m_last_b  = pick_b;
      e_address = ad;
      e_wr_data = wd;
      if (pick_b) e_b_gnt = 1'b1; else e_a_gnt = 1'b1;
      if (ad > MAX_ADDR) begin
        if (pick_b) e_b_err = 1'b1; else e_a_err = 1'b1;
        m_busy_left = 1;
      end else if (we) begin
        e_write_en = 1'b1;
        m_mem[ad] = wd;
        m_busy_left = 1;
      end else begin
        e_read_en = 1'b1;
        m_rv_wait = 2;
        m_rv_b = pick_b;
        m_rv_val = m_mem[ad];
        m_busy_left = 2;
      end
    end
    e_busy = (m_busy_left > 0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("address", {2'b00, address}, {2'b00, e_address});
    chk("wr_data", wr_data, e_wr_data);
    chk("write_en", {7'd0, write_en}, {7'd0, e_write_en});
    chk("read_en", {7'd0, read_en}, {7'd0, e_read_en});
    chk("busy", {7'd0, busy}, {7'd0, e_busy});
    chk("a_gnt", {7'd0, a_gnt}, {7'd0, e_a_gnt});
    chk("b_gnt", {7'd0, b_gnt}, {7'd0, e_b_gnt});
    chk("a_err", {7'd0, a_err}, {7'd0, e_a_err});
    chk("b_err", {7'd0, b_err}, {7'd0, e_b_err});
    chk("a_rvalid", {7'd0, a_rvalid}, {7'd0, e_a_rvalid});
    chk("b_rvalid", {7'd0, b_rvalid}, {7'd0, e_b_rvalid});
    chk("a_rdata", a_rdata, e_a_rdata);
    chk("b_rdata", b_rdata, e_b_rdata);
  endtask

  task automatic req_a(input logic we, input logic [5:0] ad, input logic [7:0] wd);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
  endtask

  task automatic req_b(input logic we, input logic [5:0] ad, input logic [7:0] wd);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  // mode 0: random traffic, 1: both requesters read back-to-back, 2: no new requests
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(negedge clock);
      check_all();
      if (e_a_gnt) a_req = 1'b0;
      if (e_b_gnt) b_req = 1'b0;
      if (!a_req) begin
        if (mode == 1) req_a(1'b0, 6'($urandom_range(0, 37)), 8'd0);
        else if (mode == 0 && $urandom_range(0, 1) == 1)
          req_a(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
      end
      if (!b_req) begin
        if (mode == 1) req_b(1'b0, 6'($urandom_range(0, 37)), 8'd0);
        else if (mode == 0 && $urandom_range(0, 1) == 1)
          req_b(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      init_mem[k] = 8'($urandom);
      m_mem[k]    = init_mem[k];
    end
    model_reset();
    repeat (3) @(negedge clock);
    check_all();
    reset_n = 1'b1;

    // single write from A
    req_a(1'b1, 6'h04, 8'hC5);
    run(4, 2);
    chk("env_mem_04", env_mem[4], 8'hC5);

    // read-back from B
    req_b(1'b0, 6'h04, 8'h00);
    run(5, 2);
    chk("readback_b", b_rdata, 8'hC5);

    // out-of-range write is rejected
    req_a(1'b1, 6'h30, 8'h99);
    run(3, 2);
    chk("env_mem_30", env_mem[6'h30], init_mem[6'h30]);

    // broadcast address passes straight through
    req_b(1'b1, 6'h01, 8'h40);
    run(3, 2);
    chk("env_mem_01", env_mem[1], 8'h40);

    // reset during CAPTURE discards the read
    req_a(1'b0, 6'h05, 8'h00);
    run(2, 2);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge clock);
    check_all();
    reset_n = 1'b1;

    // contention straight after reset: A first, then strict alternation
    run(24, 1);
    run(8, 2);

    // random traffic
    run(400, 0);
    run(8, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
